// File: rtl/seq_pattern_tx_pkg.sv
// seq_pattern_tx_pkg: shared FSM state encoding and default pattern for the serial pattern transmitter.
package seq_pattern_tx_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;
    localparam logic [3:0] DEF_PATTERN = 4'b1001;
endpackage

// File: rtl/seq_pattern_tx_piso.sv
// piso_shift: parallel-load, serial-out MSB-first shift register; shifting fills zeros.
module piso_shift
    import seq_pattern_tx_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         q_o
);
    logic [W-1:0] sh_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sh_q <= '0;
        else if (load_i) sh_q <= d_i;
        else if (shift_i) sh_q <= {sh_q[W-2:0], 1'b0};
    end
    assign q_o = sh_q[W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: sends a latched pattern MSB-first with repeats, idle gaps, busy/done handshake and abort.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int GAP_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [GAP_W-1:0] gap_len_i,
    input  logic [REP_W-1:0] rep_cnt_i,
    input  logic             abort_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             frame_sop_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int IDX_W = $clog2(PAT_W);
    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [GAP_W-1:0] gap_q, gap_cnt_q;
    logic [REP_W-1:0] reps_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q, sop_q, busy_q, done_q;
    logic             last_bit, accept, rearm, load, shift;
    logic [PAT_W-1:0] load_val;
    // The shifter drains to zero after the last bit, so ser_out idles low without gating.
    always_comb begin
        last_bit = state_q == S_SEND && idx_q == IDX_W'(PAT_W - 1);
        accept   = state_q == S_IDLE && start_i;
        rearm    = (last_bit && reps_q > REP_W'(1) && gap_q == '0)
                || (state_q == S_GAP && gap_cnt_q == GAP_W'(1));
        load     = abort_i || accept || rearm;
        shift    = state_q == S_SEND;
        load_val = abort_i ? '0 : accept ? pattern_i : pat_q;
    end
    piso_shift #(.W(PAT_W)) u_piso (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .shift_i(shift),
        .d_i    (load_val),
        .q_o    (ser_out_o)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            reps_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q <= S_SEND;
                    pat_q   <= pattern_i;
                    gap_q   <= gap_len_i;
                    reps_q  <= rep_cnt_i == '0 ? REP_W'(1) : rep_cnt_i;
                    idx_q   <= '0;
                    valid_q <= 1'b1;
                    sop_q   <= 1'b1;
                    busy_q  <= 1'b1;
                end
                S_SEND: begin
                    sop_q <= 1'b0;
                    idx_q <= idx_q + 1'b1;
                    if (last_bit) begin
                        idx_q <= '0;
                        if (reps_q > REP_W'(1)) begin
                            reps_q <= reps_q - 1'b1;
                            if (gap_q != '0) begin
                                state_q   <= S_GAP;
                                gap_cnt_q <= gap_q;
                                valid_q   <= 1'b0;
                            end else sop_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_GAP: if (gap_cnt_q == GAP_W'(1)) begin
                    state_q <= S_SEND;
                    valid_q <= 1'b1;
                    sop_q   <= 1'b1;
                end else gap_cnt_q <= gap_cnt_q - 1'b1;
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign ser_valid_o = valid_q;
    assign frame_sop_o = sop_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: table-driven, random and corner-case checks of seq_pattern_tx against a frame-stream model.
module tb_seq_pattern_tx;
    import seq_pattern_tx_pkg::*;
    localparam int PW = 4, GW = 4, RW = 4;
    logic          clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [PW-1:0] pattern_i = '0;
    logic [GW-1:0] gap_len_i = '0;
    logic [RW-1:0] rep_cnt_i = '0;
    logic          ser_out_o, ser_valid_o, frame_sop_o, busy_o, done_o;
    int            checks = 0, errors = 0;
    logic [4:0]    exp_q[$];

    seq_pattern_tx #(.PAT_W(PW), .GAP_W(GW), .REP_W(RW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .pattern_i  (pattern_i),
        .gap_len_i  (gap_len_i),
        .rep_cnt_i  (rep_cnt_i),
        .abort_i    (abort_i),
        .ser_out_o  (ser_out_o),
        .ser_valid_o(ser_valid_o),
        .frame_sop_o(frame_sop_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [PW-1:0] pat;
        int gap;
        int rep;
        int exp_len;
        int exp_sop;
        int exp_det;
    } vec_t;

    function automatic logic [4:0] outv();
        return {ser_out_o, ser_valid_o, frame_sop_o, busy_o, done_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", n, $time, act, req);
        end
    endtask

    // Expected per-cycle {ser_out,valid,sop,busy,done} from the first bit through one idle cycle.
    function automatic void build(input logic [PW-1:0] p, input int g, input int r);
        int n = (r == 0) ? 1 : r;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < PW; b++) exp_q.push_back({p[PW-1-b], 1'b1, b == 0, 1'b1, 1'b0});
            if (i < n - 1) for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);
    endfunction

    task automatic run_frame(input logic [PW-1:0] p, input int g, input int r, input bit junk,
                             output int sops, output int dpos, output int dets);
        logic [3:0] hist = '0;
        int cnt = 0;
        pattern_i = p; gap_len_i = g[GW-1:0]; rep_cnt_i = r[RW-1:0]; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        build(p, g, r);
        sops = 0; dpos = -1; dets = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check("stream", {27'd0, outv()}, {27'd0, exp_q[i]});
            if (frame_sop_o) sops++;
            if (done_o && dpos < 0) dpos = i + 1;
            hist = {hist[2:0], ser_out_o};
            cnt++;
            if (cnt >= 4 && hist == DEF_PATTERN) begin
                dets++;
                cnt = 0;
            end
            if (i < exp_q.size() - 1) begin
                start_i   = junk ? 1'($urandom) : 1'b0;
                pattern_i = PW'($urandom);
                gap_len_i = GW'($urandom);
                rep_cnt_i = RW'($urandom);
                tick();
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        vec_t vt[7];
        int sops, dpos, dets;
        vt[0] = '{4'b1001, 0, 1, 5, 1, 1};
        vt[1] = '{4'b1001, 2, 3, 17, 3, 3};
        vt[2] = '{4'b1001, 0, 2, 9, 2, 2};
        vt[3] = '{4'b0110, 0, 2, 9, 2, 1};
        vt[4] = '{4'b1111, 15, 0, 5, 1, -1};
        vt[5] = '{4'b1010, 1, 4, 20, 4, -1};
        vt[6] = '{4'b0001, 3, 2, 12, 2, -1};

        repeat (2) @(posedge clk_i);
        #1;
        check("reset", {27'd0, outv()}, 32'd0);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle", {27'd0, outv()}, 32'd0);
        end

        for (int k = 0; k < 7; k++) begin
            run_frame(vt[k].pat, vt[k].gap, vt[k].rep, k[0], sops, dpos, dets);
            check("len", dpos, vt[k].exp_len);
            check("sops", sops, vt[k].exp_sop);
            if (vt[k].exp_det >= 0) check("det", dets, vt[k].exp_det);
        end

        for (int k = 0; k < 20; k++)
            run_frame(PW'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, sops, dpos, dets);

        // Abort on the second bit of repeat 2 of 3.
        pattern_i = 4'b1001; gap_len_i = 4'd1; rep_cnt_i = 4'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        build(4'b1001, 1, 3);
        for (int i = 0; i <= 6; i++) begin
            check("pre_abort", {27'd0, outv()}, {27'd0, exp_q[i]});
            if (i < 6) tick();
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_idle", {27'd0, outv()}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", {27'd0, outv()}, 32'd0);
        end
        abort_i = 1'b1; start_i = 1'b1;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        check("abort_prio", {27'd0, outv()}, 32'd0);
        tick();
        check("abort_prio_idle", {27'd0, outv()}, 32'd0);
        run_frame(4'b1001, 1, 3, 1'b0, sops, dpos, dets);
        check("post_abort_len", dpos, 15);

        // Asynchronous reset in the middle of a gap.
        pattern_i = 4'b1001; gap_len_i = 4'd3; rep_cnt_i = 4'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        build(4'b1001, 3, 2);
        for (int i = 0; i <= 4; i++) begin
            check("pre_rst", {27'd0, outv()}, {27'd0, exp_q[i]});
            if (i < 4) tick();
        end
        check("in_gap_busy", {31'd0, busy_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1 check("rst_async", {27'd0, outv()}, 32'd0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst", {27'd0, outv()}, 32'd0);
        end
        run_frame(4'b1001, 0, 1, 1'b0, sops, dpos, dets);
        check("post_rst_len", dpos, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
